// File: rtl/bsg_logic_op_pkg.sv
// Shared types for the bsg_logic_op_pipe bitwise logic unit.
package bsg_logic_op_pkg;

    localparam int unsigned bsg_logic_op_width_gp = 2;

    typedef enum logic [bsg_logic_op_width_gp-1:0] {
        e_and  = 2'b00,
        e_or   = 2'b01,
        e_xor  = 2'b10,
        e_andn = 2'b11
    } bsg_logic_op_e;

endpackage

// File: rtl/bsg_logic_op_slice.sv
// One valid/data register slice with valid/ready handshake on both sides.
// ready_o is combinational from ready_i so a full chain can still shift every cycle.
module bsg_logic_op_slice
    import bsg_logic_op_pkg::*;
#(
    parameter int unsigned width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i
);

    logic               v_q, v_d;
    logic [width_p-1:0] data_q, data_d;

    // Slice may load when empty or when its contents leave this cycle.
    assign ready_o = !v_q || ready_i;

    // Next-state: on advance take the upstream valid; data only moves on a real transfer.
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (ready_o) begin
            v_d = v_i;
            if (v_i) begin
                data_d = data_i;
            end
        end
    end

    // Slice registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q    <= 1'b0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    assign v_o    = v_q;
    assign data_o = data_q;

endmodule

// File: rtl/bsg_logic_op_pipe.sv
// Pipelined bitwise logic unit: AND/OR/XOR/ANDN on two operands, result carried
// through stages_p valid/ready-yumi register slices.
// Optional feature macro: BSG_LOGIC_OP_PIPE_REDUCE_EN adds all_o (&result) and
// any_o (|result), captured with the result and carried alongside it.
module bsg_logic_op_pipe
    import bsg_logic_op_pkg::*;
#(
    parameter int unsigned width_p  = 16,
    parameter int unsigned stages_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    input  bsg_logic_op_e      op_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
`ifdef BSG_LOGIC_OP_PIPE_REDUCE_EN
    output logic               all_o,
    output logic               any_o,
`endif
    input  logic               yumi_i
);

`ifdef BSG_LOGIC_OP_PIPE_REDUCE_EN
    localparam int unsigned payload_w_lp = width_p + 2;
`else
    localparam int unsigned payload_w_lp = width_p;
`endif

    logic [width_p-1:0]      op_result;
    logic [payload_w_lp-1:0] payload_in;

    // Element k feeds slice k; element stages_p is the pipe output.
    logic                    v_chain     [stages_p+1];
    logic                    ready_chain [stages_p+1];
    logic [payload_w_lp-1:0] data_chain  [stages_p+1];

    // Op mux: result is formed at the input so op_i only matters at accept.
    always_comb begin
        op_result = a_i & b_i;
        unique case (op_i)
            e_and:  op_result = a_i & b_i;
            e_or:   op_result = a_i | b_i;
            e_xor:  op_result = a_i ^ b_i;
            e_andn: op_result = a_i & ~b_i;
        endcase
    end

    // Payload packing: reduction flags sit above the result when enabled.
    always_comb begin
`ifdef BSG_LOGIC_OP_PIPE_REDUCE_EN
        payload_in = {&op_result, |op_result, op_result};
`else
        payload_in = op_result;
`endif
    end

    assign v_chain[0]           = v_i;
    assign data_chain[0]        = payload_in;
    assign ready_chain[stages_p] = yumi_i;

    for (genvar k = 0; k < stages_p; k++) begin : g_stage
        bsg_logic_op_slice #(
            .width_p (payload_w_lp)
        ) u_slice (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .v_i     (v_chain[k]),
            .ready_o (ready_chain[k]),
            .data_i  (data_chain[k]),
            .v_o     (v_chain[k+1]),
            .data_o  (data_chain[k+1]),
            .ready_i (ready_chain[k+1])
        );
    end

    // Nothing is accepted while reset is held.
    assign ready_o = !reset_i && ready_chain[0];
    assign v_o     = v_chain[stages_p];
    assign data_o  = data_chain[stages_p][width_p-1:0];

`ifdef BSG_LOGIC_OP_PIPE_REDUCE_EN
    assign any_o = data_chain[stages_p][width_p];
    assign all_o = data_chain[stages_p][width_p+1];
`endif

`ifndef SYNTHESIS
    // Consumer must not take a result that is not there.
    yumi_protocol_a : assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
        else $error("yumi_i asserted while v_o is low");
`endif

endmodule
